// File: rtl/tba_if.sv
// tba_if: request/grant/tick bundle between the two divider channels and the
// shared prescaler arbiter. The arbiter side uses the slave modport.
interface tba_if #(
  parameter int DW = 3,
  parameter int NW = 4
);
  logic          c_up;
  logic          req0;
  logic          req1;
  logic [DW-1:0] div0;
  logic [DW-1:0] div1;
  logic [NW-1:0] num0;
  logic [NW-1:0] num1;
  logic          gnt0;
  logic          gnt1;
  logic          tick;
  logic          done0;
  logic          done1;
  logic          busy;

  modport master (
    output c_up, req0, req1, div0, div1, num0, num1,
    input  gnt0, gnt1, tick, done0, done1, busy
  );

  modport slave (
    input  c_up, req0, req1, div0, div1, num0, num1,
    output gnt0, gnt1, tick, done0, done1, busy
  );
endinterface

// File: rtl/tick_burst_arb.sv
// tick_burst_arb: round-robin owner of the shared modulo-D prescaler. The
// granted channel gets num ticks, one per max(div,1) enabled cycles, then a
// one-cycle done pulse.
// Optional feature macro: TBA_ABORT_EN -- dropping the owner's req during RUN
// abandons the burst without a done pulse.
module tick_burst_arb #(
  parameter int DW = 3,
  parameter int NW = 4
) (
  input logic   clk,
  input logic   rst_b,
  input logic   clr,
  tba_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic          lp, lp_n;          // last-served channel
  logic          own, own_n;        // channel holding the prescaler
  logic [DW-1:0] div_r, div_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [NW-1:0] num_r, num_n;
  logic [NW-1:0] tcnt, tcnt_n;
  logic [1:0]    gnt, gnt_n;        // index 0/1 = channel 0/1
  logic [1:0]    done, done_n;
  logic          tick, tick_n;

  logic          win;
  logic [DW-1:0] win_div;
  logic [NW-1:0] win_num;
  logic          wrap;
  logic          abort;

  // Arbitration: a lone request wins; on a tie the channel not served last wins.
  assign win     = (bus.req0 && bus.req1) ? ~lp : bus.req1;
  assign win_div = win ? bus.div1 : bus.div0;
  assign win_num = win ? bus.num1 : bus.num0;

  // Divisors of 0 and 1 both mean a tick on every enabled cycle.
  assign wrap = (div_r <= DW'(1)) || (cnt == div_r - DW'(1));

`ifdef TBA_ABORT_EN
  assign abort = (state == RUN) && !(own ? bus.req1 : bus.req0);
`else
  assign abort = 1'b0;
`endif

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    // NOTE: every target gets a default here so no path leaves a variable
    // unassigned; a missing default would infer a latch.
    state_n = state;
    lp_n    = lp;
    own_n   = own;
    div_n   = div_r;
    num_n   = num_r;
    cnt_n   = cnt;
    tcnt_n  = tcnt;
    gnt_n   = gnt;
    done_n  = 2'b00;
    tick_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          own_n  = win;
          div_n  = win_div;
          num_n  = win_num;
          cnt_n  = '0;
          tcnt_n = '0;
          if (win_num == '0) begin
            // Zero-length burst completes without ever owning the counter.
            state_n = DONE;
            done_n  = win ? 2'b10 : 2'b01;
          end else begin
            state_n = RUN;
            gnt_n   = win ? 2'b10 : 2'b01;
          end
        end
      end

      RUN: begin
        if (abort) begin
          state_n = IDLE;
          gnt_n   = 2'b00;
          cnt_n   = '0;
          tcnt_n  = '0;
          lp_n    = own;
        end else if (bus.c_up) begin
          if (wrap) begin
            cnt_n  = '0;
            tick_n = 1'b1;
            tcnt_n = tcnt + NW'(1);
            if (tcnt + NW'(1) == num_r) begin
              state_n = DONE;
              gnt_n   = 2'b00;
              done_n  = own ? 2'b10 : 2'b01;
            end
          end else begin
            cnt_n = cnt + DW'(1);
          end
        end
      end

      DONE: begin
        state_n = IDLE;
        lp_n    = own;
      end

      default: state_n = IDLE;
    endcase
  end

  // State register; clr has the same effect as reset but on the clock edge.
  always_ff @(posedge clk or negedge rst_b) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_b) begin
      state <= IDLE;
      lp    <= 1'b1;
      own   <= 1'b0;
      div_r <= '0;
      num_r <= '0;
      cnt   <= '0;
      tcnt  <= '0;
      gnt   <= 2'b00;
      done  <= 2'b00;
      tick  <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      lp    <= 1'b1;
      own   <= 1'b0;
      div_r <= '0;
      num_r <= '0;
      cnt   <= '0;
      tcnt  <= '0;
      gnt   <= 2'b00;
      done  <= 2'b00;
      tick  <= 1'b0;
    end else begin
      state <= state_n;
      lp    <= lp_n;
      own   <= own_n;
      div_r <= div_n;
      num_r <= num_n;
      cnt   <= cnt_n;
      tcnt  <= tcnt_n;
      gnt   <= gnt_n;
      done  <= done_n;
      tick  <= tick_n;
    end
  end

  assign bus.gnt0  = gnt[0];
  assign bus.gnt1  = gnt[1];
  assign bus.done0 = done[0];
  assign bus.done1 = done[1];
  assign bus.tick  = tick;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_tick_burst_arb.sv
// tb_tick_burst_arb: table of single bursts checked through an expected-tick
// queue, plus hand-written sequences for arbitration order, enable gating,
// zero-length bursts, reset/clr mid-burst and abort.
module tb_tick_burst_arb;
  localparam int DW = 3;
  localparam int NW = 4;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  tba_if #(.DW(DW), .NW(NW)) bus ();

  tick_burst_arb #(.DW(DW), .NW(NW)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (clr),
    .bus   (bus)
  );

  // Edge counter: at a negedge, cyc equals the number of the last rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit both_seen = 1'b0;
  int exp_q[$];

  always @(negedge clk) if (bus.gnt0 && bus.gnt1) both_seen <= 1'b1;

  typedef struct {
    bit ch;
    int div;
    int num;
    int period;   // expected cycles between ticks
    int ticks;    // expected number of ticks
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input bit ch, input bit v, input int d, input int n);
    if (ch) begin
      bus.req1 = v; bus.div1 = DW'(d); bus.num1 = NW'(n);
    end else begin
      bus.req0 = v; bus.div0 = DW'(d); bus.num0 = NW'(n);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_gnt0"},  int'(bus.gnt0),  0);
    check({tag, "_gnt1"},  int'(bus.gnt1),  0);
    check({tag, "_tick"},  int'(bus.tick),  0);
    check({tag, "_done0"}, int'(bus.done0), 0);
    check({tag, "_done1"}, int'(bus.done1), 0);
    check({tag, "_busy"},  int'(bus.busy),  0);
  endtask

  task automatic wait_gnt(input bit ch, input int limit, output int g);
    g = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (ch ? bus.gnt1 : bus.gnt0) begin
        g = cyc;
        break;
      end
    end
    check("gnt_seen", int'(g >= 0), 1);
  endtask

  // One burst from a single requester with c_up held high.
  task automatic run_burst(input vec_t v);
    int r, g, done_cyc;
    bit other;
    @(negedge clk);
    r = cyc;
    set_req(v.ch, 1'b1, v.div, v.num);
    wait_gnt(v.ch, 4, g);
    check("req_gnt_lat", g - r, 1);
    for (int k = 1; k <= v.ticks; k++) exp_q.push_back(g + k * v.period);
    done_cyc = -1;
    other    = 1'b0;
    for (int i = 0; i < v.ticks * v.period + 3; i++) begin
      @(negedge clk);
      if (bus.tick) begin
        if (exp_q.size() == 0) check("tick_unexpected", cyc, -1);
        else                   check("tick_cyc", cyc, exp_q.pop_front());
      end
      if (v.ch ? bus.done0 : bus.done1) other = 1'b1;
      if ((v.ch ? bus.done1 : bus.done0) && done_cyc < 0) begin
        done_cyc = cyc;
        set_req(v.ch, 1'b0, 0, 0);
      end
    end
    set_req(v.ch, 1'b0, 0, 0);
    check("done_cyc", done_cyc, g + v.ticks * v.period);
    check("ticks_missing", exp_q.size(), 0);
    exp_q.delete();
    check("gnt_after_done", int'(v.ch ? bus.gnt1 : bus.gnt0), 0);
    check("wrong_done", int'(other), 0);
  endtask

  initial begin
    int r, g, w, dc, dw, tc, tn, d0, g0_at, g1_rise, d1;

    vecs[0] = '{ch: 1'b0, div: 3, num: 2, period: 3, ticks: 2};
    vecs[1] = '{ch: 1'b1, div: 0, num: 3, period: 1, ticks: 3};
    vecs[2] = '{ch: 1'b0, div: 1, num: 2, period: 1, ticks: 2};
    vecs[3] = '{ch: 1'b1, div: 5, num: 1, period: 5, ticks: 1};
    vecs[4] = '{ch: 1'b0, div: 7, num: 2, period: 7, ticks: 2};
    vecs[5] = '{ch: 1'b1, div: 2, num: 3, period: 2, ticks: 3};

    bus.c_up = 1'b1;
    set_req(1'b0, 1'b0, 0, 0);
    set_req(1'b1, 1'b0, 0, 0);

    // Reset state.
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_b = 1'b1;

    // Simultaneous held requests from reset: ch0, ch1, ch0, ch1.
    @(negedge clk);
    r = cyc;
    set_req(1'b0, 1'b1, 2, 1);
    set_req(1'b1, 1'b1, 2, 1);
    dc = -1;
    for (int k = 0; k < 4; k++) begin
      g = -1; w = -1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.gnt0 || bus.gnt1) begin g = cyc; w = int'(bus.gnt1); break; end
      end
      check("rr_order", w, k % 2);
      if (k == 0) check("rr_latency", g - r, 1);
      else        check("rr_gap", g - dc, 2);
      dc = -1; dw = -1;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (bus.done0 || bus.done1) begin dc = cyc; dw = int'(bus.done1); break; end
      end
      check("rr_done_cyc", dc, g + 2);
      check("rr_done_ch", dw, k % 2);
    end
    set_req(1'b0, 1'b0, 0, 0);
    set_req(1'b1, 1'b0, 0, 0);
    repeat (2) @(negedge clk);

    // Table of single bursts.
    for (int i = 0; i < 6; i++) run_burst(vecs[i]);

    // Enable gating: c_up low on alternate cycles, tick after 3 enabled edges.
    @(negedge clk);
    set_req(1'b0, 1'b1, 3, 1);
    wait_gnt(1'b0, 4, g);
    bus.c_up = 1'b0;
    tc = -1; tn = 0; dc = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tick) begin tn++; if (tc < 0) tc = cyc; end
      if (bus.done0 && dc < 0) begin dc = cyc; set_req(1'b0, 1'b0, 0, 0); end
      bus.c_up = ~bus.c_up;
    end
    bus.c_up = 1'b1;
    check("gate_tick_cyc", tc, g + 6);
    check("gate_tick_cnt", tn, 1);
    check("gate_done_cyc", dc, g + 6);

    // num0 = 0: done0 one cycle after the arbitration edge, no tick.
    @(negedge clk);
    r = cyc;
    set_req(1'b0, 1'b1, 3, 0);
    dc = -1; tn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.tick) tn++;
      if (bus.done0 && dc < 0) begin dc = cyc; set_req(1'b0, 1'b0, 0, 0); end
    end
    check("num0_done_cyc", dc, r + 1);
    check("num0_ticks", tn, 0);

    // Reset mid-burst: outputs drop at once, lp returns to 1, no done pulse.
    run_burst('{ch: 1'b0, div: 2, num: 1, period: 2, ticks: 1});
    @(negedge clk);
    set_req(1'b1, 1'b1, 7, 3);
    wait_gnt(1'b1, 4, g);
    repeat (3) @(negedge clk);
    #1 rst_b = 1'b0;
    #1 check_zero("async_rst");
    set_req(1'b1, 1'b0, 0, 0);
    @(negedge clk);
    rst_b = 1'b1;
    tn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tn += int'(bus.done0) + int'(bus.done1) + int'(bus.tick) + int'(bus.gnt1);
    end
    check("rst_quiet", tn, 0);
    set_req(1'b0, 1'b1, 2, 1);
    set_req(1'b1, 1'b1, 2, 1);
    w = -1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin w = int'(bus.gnt1); break; end
    end
    check("rst_lp_winner", w, 0);
    dc = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.done0) begin dc = cyc; break; end
    end
    set_req(1'b0, 1'b0, 0, 0);
    set_req(1'b1, 1'b0, 0, 0);
    check("rst_next_done", int'(dc >= 0), 1);
    repeat (2) @(negedge clk);

    // clr on the same edge as the first wrap: clr wins, no tick.
    @(negedge clk);
    set_req(1'b0, 1'b1, 3, 2);
    wait_gnt(1'b0, 4, g);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check_zero("clr");
    clr = 1'b0;
    set_req(1'b0, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    check("clr_no_done", int'(bus.done0), 0);
    run_burst('{ch: 1'b1, div: 2, num: 2, period: 2, ticks: 2});

    // Drop req0 after the first tick of a 4-tick burst, req1 pending.
    @(negedge clk);
    set_req(1'b0, 1'b1, 2, 4);
    wait_gnt(1'b0, 4, g);
    set_req(1'b1, 1'b1, 2, 1);
    repeat (2) @(negedge clk);
    check("abort_first_tick", int'(bus.tick), 1);
    set_req(1'b0, 1'b0, 0, 0);
    tn = 0; d0 = -1; g0_at = -1; g1_rise = -1; d1 = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) g0_at = int'(bus.gnt0);
      if (bus.tick && !bus.gnt1 && d1 < 0 && g1_rise < 0) tn++;
      if (bus.done0 && d0 < 0) d0 = cyc;
      if (bus.gnt1 && g1_rise < 0) g1_rise = cyc;
      if (bus.done1 && d1 < 0) begin d1 = cyc; set_req(1'b1, 1'b0, 0, 0); end
    end
    set_req(1'b1, 1'b0, 0, 0);
`ifdef TBA_ABORT_EN
    check("abort_gnt0_low", g0_at, 0);
    check("abort_more_ticks", tn, 0);
    check("abort_done0", d0, -1);
    check("abort_gnt1_cyc", g1_rise, g + 4);
    check("abort_done1_cyc", d1, g + 6);
`else
    check("noabort_gnt0", g0_at, 1);
    check("noabort_more_ticks", tn, 3);
    check("noabort_done0", d0, g + 8);
    check("noabort_gnt1_cyc", g1_rise, g + 10);
    check("noabort_done1_cyc", d1, g + 12);
`endif

    check("gnt_onehot", int'(both_seen), 0);
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tick_burst_arb.md
# tick_burst_arb

Arbiter and sequencer for the shared modulo-D prescaler used by the clock-divider blocks. Two requesters each post a divisor and a tick count. The block grants the prescaler to one of them round-robin, then runs the modulo counter under the global count enable. It emits one tick per divisor period until the requested number of ticks has been produced, then signals completion and releases the prescaler.

## Interface
- DW, 3, divisor width (bits)
- NW, 4, tick-count width (bits)
- clk  input  1  clock, rising edge
- rst_b  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous clear; same effect as reset, takes priority over everything else
- c_up  input  1  count enable for the prescaler; counting freezes while low
- req0, req1  input  1  request from channel 0 / 1; held high until done or abort
- div0, div1  input  DW  divisor requested by channel 0 / 1
- num0, num1  input  NW  number of ticks requested by channel 0 / 1
- gnt0, gnt1  output  1  prescaler granted to channel 0 / 1; at most one high
- tick  output  1  one-cycle pulse per divisor period of the granted burst
- done0, done1  output  1  one-cycle completion pulse for channel 0 / 1
- busy  output  1  high in RUN and DONE

## Operation
- Registers:
  - state ∈ {IDLE, RUN, DONE}
  - lp: last-served channel
  - div_r, num_r: latched divisor and count
  - cnt (DW bits): prescaler
  - tcnt (NW bits): ticks produced
  - own: granted channel
- Reset / clr values:
  - state=IDLE, lp=1, cnt=0, tcnt=0
  - all outputs 0
- IDLE:
  - Arbitration: if exactly one req is high, that channel wins. If both are high, the channel ≠ lp wins.
  - Latch the winner's div/num, clear cnt and tcnt, set own, go to RUN.
  - Exception: if the winner's num = 0, go directly to DONE with no ticks.
- RUN, c_up=1:
  - If cnt = div_r−1, or div_r ≤ 1: cnt←0, tick pulses next cycle, tcnt←tcnt+1.
  - If that tick makes tcnt = num_r: go to DONE.
  - Otherwise: cnt←cnt+1.
- RUN, c_up=0: all counters hold; no tick.
- DONE: lasts exactly one cycle; done_own=1, lp←own; then IDLE.
- Arithmetic: cnt and tcnt never wrap. div_r ≤ 1 means a tick on every enabled cycle.
- Request rules:
  - div/num are sampled only at the arbitration edge; later changes are ignored.
  - req of the non-granted channel is ignored until IDLE.
  - A req still high in IDLE after done counts as a new request.

## Timing
- gnt_own is registered:
  - rises on the edge leaving IDLE;
  - falls on the edge entering DONE or IDLE.
- req→gnt latency: 1 cycle.
- With c_up held high, the k-th tick is high during the cycle after edge G+k·D, where G is the grant edge and D = max(div_r, 1).
- done_own is high in the same cycle as the final tick.
- Back-to-back bursts:
  - minimum turnaround from done to the next grant is 2 cycles (DONE → IDLE → RUN);
  - a pending request from the other channel is served next.
- Reset mid-burst: all outputs go to 0 immediately; no done pulse.
- clr asserted on the same edge as a wrap: clr wins; no tick.

## Configuration
- TBA_ABORT_EN defined:
  - If req_own falls during RUN, the next edge goes to IDLE, clears gnt/cnt/tcnt and sets lp←own.
  - No done pulse and no further ticks.
- TBA_ABORT_EN undefined: req drop during RUN is ignored and the burst runs to completion with done.

## Test plan
- Single burst: req0, div0=3, num0=2, c_up=1.
  - Expect gnt0 one cycle after req.
  - Expect tick at G+3 and G+6.
  - Expect done0 coincident with the second tick, gnt0 low after.
- Simultaneous requests from reset, both held: req0=req1=1, each div=2, num=1.
  - Expect grant order ch0, ch1, ch0, ch1.
  - Expect at most one gnt high at a time.
  - Expect a 2-cycle gap between each done and the next grant.
- Enable gating: div0=3, num0=1, c_up low on alternate cycles.
  - Expect the tick after 3 enabled cycles (6 clk).
  - Expect cnt frozen while c_up is low.
- Degenerate values:
  - div1=0 with num1=3: expect 3 consecutive tick cycles, then done1.
  - num0=0: expect done0 one cycle after the grant edge and no tick.
- Reset/clr mid-burst:
  - rst_b low during RUN: expect all outputs 0 asynchronously, lp=1.
  - clr during RUN: the same, synchronously; the next request is served normally.
- Abort (with TBA_ABORT_EN): drop req0 after the first tick of num0=4.
  - Expect gnt0 low next cycle and no further tick or done0.
  - Expect a pending req1 granted next.
  - Without the macro: 4 ticks plus done0.
